sfp_accum_array: RTL and testbench

Output-side special-function stage for the 2D accelerator corelet, generalised to col channels with an addressable accumulation buffer.
- WS mode: accumulates per-row partial sums arriving from the OFIFO into a depth-entry buffer, then reads them out singly or as a full dump.
- OS mode: passes finished psums through directly.
- Optional ReLU on the output path; valid/ready handshakes on both the input and output sides.

---
 rtl/sfp_accum_array_if.sv | 40 ++++
 rtl/sfp_accum_array.sv | 175 +++++++++++++++++
 tb/tb_sfp_accum_array.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sfp_accum_array_if.sv
`default_nettype none
// ============================================================================
// Module   : sfp_accum_array_if
// Brief    : Command, input-beat and output-beat signals of sfp_accum_array.
// Revision : 1.0
// ============================================================================
interface sfp_accum_array_if #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ADDR_BW = 4
);
    logic                     mode_select;
    logic                     relu_en;
    logic                     in_valid;
    logic                     in_ready;
    logic [PSUM_BW*COL-1:0]   in_data;
    logic [ADDR_BW-1:0]       in_addr;
    logic                     in_first;
    logic                     rd_req;
    logic [ADDR_BW-1:0]       rd_addr;
    logic                     dump;
    logic                     clr;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic [PSUM_BW*COL-1:0]   out_data;

    modport master (
        output mode_select, relu_en, in_valid, in_data, in_addr, in_first,
               rd_req, rd_addr, dump, clr, out_ready,
        input  in_ready, busy, out_valid, out_data
    );

    modport slave (
        input  mode_select, relu_en, in_valid, in_data, in_addr, in_first,
               rd_req, rd_addr, dump, clr, out_ready,
        output in_ready, busy, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/sfp_accum_array.sv
`default_nettype none
// ============================================================================
// Module   : sfp_accum_array
// Brief    : Per-column psum accumulation buffer (WS) / pass-through (OS)
//            with saturating add, optional ReLU and a one-stage output reg.
// Revision : 1.0
// ============================================================================
module sfp_accum_array #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 16,
    parameter int ADDR_BW = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    sfp_accum_array_if.slave   bus
);

    localparam int                 c_W    = PSUM_BW * COL;
    localparam logic [ADDR_BW-1:0] c_LAST = ADDR_BW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DUMP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_BW-1:0] r_ptr;
    logic [ADDR_BW-1:0] w_ptr_nxt;
    logic [c_W-1:0]     r_buf [DEPTH];
    logic               r_mode;
    logic               r_out_valid;
    logic [c_W-1:0]     r_out_data;

    logic               w_out_free;
    logic               w_mode;
    logic               w_in_ready;
    logic               w_load;
    logic [c_W-1:0]     w_load_data;
    logic [c_W-1:0]     w_relu_data;
    logic               w_wr_en;
    logic [ADDR_BW-1:0] w_wr_addr;
    logic [c_W-1:0]     w_wr_data;
    logic [c_W-1:0]     w_acc_old;
    logic [c_W-1:0]     w_acc;

    assign w_out_free = !r_out_valid || bus.out_ready;
    // The mode register is transparent while it is allowed to update, so a
    // new mode takes effect in the same cycle it becomes latchable.
    assign w_mode     = (r_state == S_IDLE && !r_out_valid) ? bus.mode_select : r_mode;
    assign w_acc_old  = r_buf[bus.in_addr];

    for (genvar g = 0; g < COL; g++) begin : g_ch
        logic [PSUM_BW-1:0] w_a;
        logic [PSUM_BW-1:0] w_b;
        logic [PSUM_BW:0]   w_sum;
        logic [PSUM_BW-1:0] w_sat;
        logic [PSUM_BW-1:0] w_ld;

        assign w_a   = w_acc_old[g*PSUM_BW +: PSUM_BW];
        assign w_b   = bus.in_data[g*PSUM_BW +: PSUM_BW];
        assign w_sum = {w_a[PSUM_BW-1], w_a} + {w_b[PSUM_BW-1], w_b};
        // Overflow shows as disagreement between the two top bits of the
        // sign-extended sum; the extra bit carries the true sign.
        assign w_sat = (w_sum[PSUM_BW] == w_sum[PSUM_BW-1]) ? w_sum[PSUM_BW-1:0] :
                       (w_sum[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}}
                                       : {1'b0, {(PSUM_BW-1){1'b1}}});
        assign w_acc[g*PSUM_BW +: PSUM_BW] = bus.in_first ? w_b : w_sat;

        assign w_ld = w_load_data[g*PSUM_BW +: PSUM_BW];
        assign w_relu_data[g*PSUM_BW +: PSUM_BW] =
            (bus.relu_en && w_ld[PSUM_BW-1]) ? '0 : w_ld;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        w_load_data = '0;
        w_wr_en     = 1'b0;
        w_wr_addr   = bus.in_addr;
        w_wr_data   = w_acc;
        case (r_state)
            S_IDLE: begin
                if (bus.clr) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end else if (bus.dump && !w_mode) begin
                    w_state_nxt = S_DUMP;
                    w_ptr_nxt   = '0;
                end else if (bus.rd_req && !w_mode) begin
                    w_load      = w_out_free;
                    w_load_data = r_buf[bus.rd_addr];
                end else if (w_mode) begin
                    w_in_ready  = w_out_free;
                    w_load      = bus.in_valid && w_out_free;
                    w_load_data = bus.in_data;
                end else begin
                    w_in_ready  = 1'b1;
                    w_wr_en     = bus.in_valid;
                end
            end
            S_CLEAR: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_ptr;
                w_wr_data = '0;
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == c_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DUMP: begin
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_load_data = r_buf[r_ptr];
                    w_ptr_nxt   = r_ptr + 1'b1;
                    if (r_ptr == c_LAST) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_buf[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_mode      <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_relu_data;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_state == S_IDLE && !r_out_valid) begin
                r_mode <= bus.mode_select;
            end
        end
    end

    assign bus.in_ready  = w_in_ready && !reset;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_sfp_accum_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfp_accum_array
// Brief    : Directed self-checking bench for sfp_accum_array.
// Revision : 1.0
// ============================================================================
module tb_sfp_accum_array;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sfp_accum_array_if #(.COL(8), .PSUM_BW(16), .ADDR_BW(4)) bus ();

    sfp_accum_array #(.COL(8), .PSUM_BW(16), .DEPTH(16), .ADDR_BW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [127:0] rep(input logic [15:0] v);
        return {8{v}};
    endfunction

    function automatic logic [127:0] two(input logic [15:0] c0, input logic [15:0] c1);
        logic [127:0] r;
        r        = '0;
        r[15:0]  = c0;
        r[31:16] = c1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] addr, input logic first, input logic [127:0] data);
        bus.in_valid = 1'b1;
        bus.in_addr  = addr;
        bus.in_first = first;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] addr, input logic [127:0] exp);
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr;
        tick();
        bus.rd_req  = 1'b0;
        chk({tag, "_valid"}, 128'(bus.out_valid), 128'd1);
        chk({tag, "_data"}, bus.out_data, exp);
        tick();
    endtask

    initial begin
        int n;
        reset           = 1'b1;
        bus.mode_select = 1'b0;
        bus.relu_en     = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_addr     = '0;
        bus.in_first    = 1'b0;
        bus.rd_req      = 1'b0;
        bus.rd_addr     = '0;
        bus.dump        = 1'b0;
        bus.clr         = 1'b0;
        bus.out_ready   = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_out_data",  bus.out_data,        128'd0);
        chk("rst_busy",      128'(bus.busy),      128'd0);
        chk("rst_in_ready",  128'(bus.in_ready),  128'd0);
        reset = 1'b0;
        tick();

        // WS overwrite then accumulate, single read
        chk("ws_in_ready", 128'(bus.in_ready), 128'd1);
        beat(4'd3, 1'b1, rep(16'd5));
        beat(4'd3, 1'b0, rep(16'hFFFE));
        bus.rd_req = 1'b1;
        #1;
        chk("ws_in_ready_rd", 128'(bus.in_ready), 128'd0);
        bus.rd_req = 1'b0;
        rd("ws_rd3", 4'd3, rep(16'd3));
        chk("ws_out_drained", 128'(bus.out_valid), 128'd0);

        // Saturation at both rails
        beat(4'd0, 1'b1, two(16'd32000, 16'h8000));
        beat(4'd0, 1'b0, two(16'd1000, 16'hFFFB));
        rd("sat_rd0", 4'd0, two(16'h7FFF, 16'h8000));

        // OS pass-through with ReLU and back-pressure
        bus.mode_select = 1'b1;
        bus.relu_en     = 1'b1;
        tick();
        bus.in_valid  = 1'b1;
        bus.in_data   = two(16'hFFF9, 16'd9);
        bus.out_ready = 1'b0;
        #1;
        chk("os_in_ready", 128'(bus.in_ready), 128'd1);
        tick();
        chk("os_valid", 128'(bus.out_valid), 128'd1);
        chk("os_relu",  bus.out_data, two(16'd0, 16'd9));
        bus.in_data = two(16'd100, 16'd200);
        for (int i = 0; i < 3; i++) begin
            chk("os_stall_in_ready", 128'(bus.in_ready), 128'd0);
            chk("os_stall_data", bus.out_data, two(16'd0, 16'd9));
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("os_drained", 128'(bus.out_valid), 128'd0);
        bus.mode_select = 1'b0;
        bus.relu_en     = 1'b0;
        tick();

        // Dump with alternating back-pressure
        for (int a = 0; a < 16; a++) begin
            beat(4'(a), 1'b1, rep(16'(a)));
        end
        bus.dump = 1'b1;
        tick();
        bus.dump = 1'b0;
        chk("dump_busy", 128'(bus.busy), 128'd1);
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 16; cyc++) begin
            bus.out_ready = (cyc % 2 == 1);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                chk("dump_val", bus.out_data, rep(16'(n)));
                if (n == 15) chk("dump_busy_last", 128'(bus.busy), 128'd0);
                n++;
            end
            tick();
        end
        chk("dump_count", 128'(n), 128'd16);
        bus.out_ready = 1'b1;
        tick();
        chk("dump_no_extra", 128'(bus.out_valid), 128'd0);
        rd("dump_keep7", 4'd7, rep(16'd7));

        // Clear: blocks inputs for DEPTH cycles, then everything reads zero
        bus.clr = 1'b1;
        tick();
        bus.clr      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_first = 1'b1;
        bus.in_addr  = 4'd2;
        bus.in_data  = rep(16'd77);
        for (int i = 0; i < 16; i++) begin
            chk("clr_busy", 128'(bus.busy), 128'd1);
            chk("clr_in_ready", 128'(bus.in_ready), 128'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("clr_done", 128'(bus.busy), 128'd0);
        rd("clr_rd0",  4'd0,  128'd0);
        rd("clr_rd2",  4'd2,  128'd0);
        rd("clr_rd15", 4'd15, 128'd0);

        // Reset in the middle of a dump
        for (int a = 0; a < 16; a++) begin
            beat(4'(a), 1'b1, rep(16'(a + 1)));
        end
        bus.dump = 1'b1;
        tick();
        bus.dump = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_dump_busy", 128'(bus.busy), 128'd1);
        chk("mid_dump_val",  bus.out_data, rep(16'd5));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_dump_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_dump_busy",  128'(bus.busy),      128'd0);
        rd("rst_rd3", 4'd3, 128'd0);
        rd("rst_rd9", 4'd9, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
